gain_ctrl: RTL and testbench

Sample-rate gain controller that sits between the ADC sample interface and the DAC output register in the audio processor path. It detects each new sample from the data_valid level and sequences one shared signed multiply, shift and saturate per sample. Gain is user-adjustable by up/down pulses and ramped one step per RAMP_DIV samples toward its target, so gain changes do not produce clicks. It replaces fixed-gain processing such as the ×2 stage.

---
 rtl/gain_ctrl.sv | 149 ++++++++++++++
 tb/tb_gain_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gain_ctrl.sv
// Sample-rate gain controller: catches the data_valid rising edge, then runs
// one shared signed multiply / shift / saturate per sample. The gain actually
// applied (gain_cur) ramps one code per RAMP_DIV samples toward the user
// target, so gain changes never step abruptly.
module gain_ctrl #(
  parameter int DATA_W       = 10,
  parameter int OFFSET       = 512,
  parameter int GAIN_W       = 4,
  parameter int DEFAULT_GAIN = 4,
  parameter int RAMP_DIV     = 1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              gain_up,
  input  logic              gain_down,
  input  logic              mute,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready,
  output logic [GAIN_W-1:0] gain_cur,
  output logic              busy,
  output logic              overrun
);
  // Product holds a signed DATA_W sample times an unsigned GAIN_W code.
  localparam int PW = DATA_W + GAIN_W + 1;

  localparam logic [DATA_W-1:0]    OFF   = DATA_W'(OFFSET);
  localparam logic [GAIN_W-1:0]    GMAX  = '1;
  localparam logic [GAIN_W-1:0]    GDEF  = GAIN_W'(DEFAULT_GAIN);
  localparam logic [7:0]           RLAST = 8'(RAMP_DIV - 1);
  localparam logic signed [PW-1:0] SMAX  = PW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN  = ~SMAX;

  typedef enum logic [2:0] {IDLE, CAP, MUL, SAT, OUT} state_t;

  state_t                    state, state_nx;
  logic                      dv_q;
  logic                      sample_edge;
  logic signed [DATA_W-1:0]  x_q;
  logic        [GAIN_W-1:0]  g_q;
  logic signed [PW-1:0]      p_q;
  logic signed [PW-1:0]      sh;
  logic        [DATA_W-1:0]  s_n;
  logic        [DATA_W-1:0]  s_q;
  logic        [GAIN_W-1:0]  target;
  logic        [GAIN_W-1:0]  eff_target;
  logic        [7:0]         ramp_cnt;

  assign sample_edge = data_valid & ~dv_q;
  assign eff_target  = mute ? '0 : target;

  // Edge register loads every cycle, reset included, so a level already high
  // at reset release is not treated as a new sample.
  always_ff @(posedge sysclk) begin
    dv_q <= data_valid;
  end

  // FSM state register.
  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next state: a fixed five-cycle walk once a sample edge is seen.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_edge) state_nx = CAP;
      CAP:     state_nx = MUL;
      MUL:     state_nx = SAT;
      SAT:     state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    data_ready = (state == OUT);
    busy       = (state != IDLE);
  end

  // Divide by four (floor) and clamp into the signed sample range.
  always_comb begin
    sh = p_q >>> 2;
    if (sh > SMAX)      s_n = SMAX[DATA_W-1:0];
    else if (sh < SMIN) s_n = SMIN[DATA_W-1:0];
    else                s_n = sh[DATA_W-1:0];
  end

  // Datapath: capture, multiply, saturate, then publish in offset-binary.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      x_q      <= '0;
      g_q      <= '0;
      p_q      <= '0;
      s_q      <= '0;
      data_out <= OFF;
    end else begin
      case (state)
        CAP: begin
          x_q <= data_in - OFF;
          g_q <= gain_cur;
        end
        MUL: p_q <= $signed({{(GAIN_W+1){x_q[DATA_W-1]}}, x_q}) *
                    $signed({{(DATA_W+1){1'b0}}, g_q});
        SAT: s_q <= s_n;
        OUT: data_out <= s_q + OFF;
        default: ;
      endcase
    end
  end

  // Target follows the up/down pulses regardless of FSM activity.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      target <= GDEF;
    end else begin
      case ({gain_up, gain_down})
        2'b10:   if (target != GMAX) target <= target + 1'b1;
        2'b01:   if (target != '0)   target <= target - 1'b1;
        default: ;
      endcase
    end
  end

  // Ramp gain_cur one code toward the effective target, only at sample output.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      ramp_cnt <= '0;
      gain_cur <= GDEF;
    end else if (state == OUT) begin
      if (ramp_cnt == RLAST) begin
        ramp_cnt <= '0;
        if (gain_cur < eff_target)      gain_cur <= gain_cur + 1'b1;
        else if (gain_cur > eff_target) gain_cur <= gain_cur - 1'b1;
      end else begin
        ramp_cnt <= ramp_cnt + 1'b1;
      end
    end
  end

  // Sticky flag for a sample edge that arrived while a sample was in flight.
  always_ff @(posedge sysclk) begin
    if (reset)                             overrun <= 1'b0;
    else if (sample_edge && state != IDLE) overrun <= 1'b1;
  end
endmodule

// File: tb/tb_gain_ctrl.sv
// Directed bench for gain_ctrl: a table of samples with hand-computed outputs
// and gains, plus short sequences for reset, overrun and target saturation.
module tb_gain_ctrl;
  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       data_valid = 1'b0;
  logic [9:0] data_in = '0;
  logic       gain_up = 1'b0;
  logic       gain_down = 1'b0;
  logic       mute = 1'b0;
  logic [9:0] data_out;
  logic       data_ready;
  logic [3:0] gain_cur;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  gain_ctrl dut (
    .sysclk(sysclk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
    .gain_up(gain_up), .gain_down(gain_down), .mute(mute),
    .data_out(data_out), .data_ready(data_ready), .gain_cur(gain_cur),
    .busy(busy), .overrun(overrun)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int din;
    int ups;
    int downs;
    int mute_lvl;
    int exp_out;
    int exp_gain;
  } vec_t;

  vec_t vecs[24];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int up, input int dn);
    gain_up = up[0];
    gain_down = dn[0];
    tick();
    gain_up = 1'b0;
    gain_down = 1'b0;
  endtask

  // One sample: raise data_valid, expect data_ready exactly 4 cycles later,
  // then check the published value and the gain after the ramp step.
  task automatic do_sample(input int din, input int exp_out, input int exp_gain);
    int lat;
    lat = -1;
    data_in = din[9:0];
    data_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (data_ready) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 4);
    tick();
    chk("data_out", int'(data_out), exp_out);
    chk("gain_cur", int'(gain_cur), exp_gain);
    chk("ready_one_cycle", int'(data_ready), 0);
    data_valid = 1'b0;
    tick();
  endtask

  initial begin
    int seen;
    int nrdy;
    int last_out;

    vecs[0]  = '{700, 0, 0, 0, 700, 4};
    vecs[1]  = '{600, 4, 0, 0, 600, 5};
    vecs[2]  = '{600, 0, 0, 0, 622, 6};
    vecs[3]  = '{600, 0, 0, 0, 644, 7};
    vecs[4]  = '{600, 0, 0, 0, 666, 8};
    vecs[5]  = '{600, 0, 0, 0, 688, 8};
    vecs[6]  = '{1000, 0, 0, 0, 1023, 8};
    vecs[7]  = '{0, 0, 0, 0, 0, 8};
    vecs[8]  = '{600, 0, 3, 0, 688, 7};
    vecs[9]  = '{600, 0, 0, 0, 666, 6};
    vecs[10] = '{600, 0, 0, 0, 644, 5};
    vecs[11] = '{511, 0, 0, 0, 510, 5};
    vecs[12] = '{400, 0, 0, 0, 372, 5};
    vecs[13] = '{700, 0, 1, 0, 747, 4};
    vecs[14] = '{700, 0, 0, 1, 700, 3};
    vecs[15] = '{700, 0, 0, 1, 653, 2};
    vecs[16] = '{700, 0, 0, 1, 606, 1};
    vecs[17] = '{700, 0, 0, 1, 559, 0};
    vecs[18] = '{700, 0, 0, 1, 512, 0};
    vecs[19] = '{700, 0, 0, 0, 512, 1};
    vecs[20] = '{700, 0, 0, 0, 559, 2};
    vecs[21] = '{700, 0, 0, 0, 606, 3};
    vecs[22] = '{700, 0, 0, 0, 653, 4};
    vecs[23] = '{700, 0, 0, 0, 700, 4};

    // Reset with data_valid high: the held level must not start a sample.
    data_valid = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_data_out", int'(data_out), 512);
    chk("rst_gain_cur", int'(gain_cur), 4);
    chk("rst_data_ready", int'(data_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy || data_ready) seen++;
    end
    chk("held_level_no_trigger", seen, 0);
    data_valid = 1'b0;
    tick();

    // Table of samples: pulses and mute level applied before each sample.
    for (int v = 0; v < 24; v++) begin
      for (int k = 0; k < vecs[v].ups; k++) pulse(1, 0);
      for (int k = 0; k < vecs[v].downs; k++) pulse(0, 1);
      mute = vecs[v].mute_lvl[0];
      tick();
      do_sample(vecs[v].din, vecs[v].exp_out, vecs[v].exp_gain);
    end
    mute = 1'b0;
    chk("no_overrun_yet", int'(overrun), 0);

    // Overrun: second edge two cycles after the first is dropped.
    data_in = 10'd700;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    data_in = 10'd300;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    nrdy = 0;
    last_out = -1;
    for (int i = 0; i < 12; i++) begin
      if (data_ready) nrdy++;
      tick();
      if (nrdy == 1 && last_out < 0) last_out = int'(data_out);
    end
    chk("ovr_ready_count", nrdy, 1);
    chk("ovr_data_out", last_out, 700);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_busy", int'(busy), 0);
    chk("ovr_gain", int'(gain_cur), 4);

    // Reset in the middle of a sample: no output, state back to reset values.
    data_in = 10'd900;
    data_valid = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 8; i++) begin
      if (data_ready) nrdy++;
      tick();
    end
    chk("midrst_ready_count", nrdy, 0);
    chk("midrst_data_out", int'(data_out), 512);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_busy", int'(busy), 0);
    data_valid = 1'b0;
    tick();

    // Target saturation: 12 ups from 4 stop at 15; up+down together is a no-op.
    for (int k = 0; k < 12; k++) pulse(1, 0);
    pulse(1, 1);
    tick();
    for (int i = 0; i < 12; i++)
      do_sample(512, 512, (5 + i > 15) ? 15 : 5 + i);
    pulse(0, 1);
    tick();
    do_sample(512, 512, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
